snn_step_scheduler: RTL and testbench

Timestep controller and force-spike arbiter for network_tiny.
- Collects force-spike requests from R independent requesters using round-robin arbitration, and queues them.
- On each start_step it sequences one SNN timestep: drain the queued forced spikes onto the network's force-spike port, one per cycle, then enable each of the T neuron blocks in turn, then signal completion.
- Sits between the host/stimulus logic and network_tiny, inside project_top.

---
 rtl/snn_pkg.sv | 32 +++
 rtl/snn_rr_arbiter.sv | 46 ++++
 rtl/snn_step_scheduler.sv | 174 +++++++++++++++++
 tb/tb_snn_step_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// snn_pkg: shared network dimensions and the types used by the step scheduler.
//   T, N           : neuron blocks and neurons per block
//   TW, NW         : select widths for block / neuron indices
//   STEP_CNT_W     : width of the completed-step counter
//   force_req_t    : one queued force-spike request {block, neuron}
//   sched_state_t  : timestep sequencer states
package snn_pkg;

    localparam int unsigned T          = 4;
    localparam int unsigned N          = 8;
    localparam int unsigned TW         = (T > 1) ? $clog2(T) : 1;
    localparam int unsigned NW         = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned STEP_CNT_W = 16;

    typedef struct packed {
        logic [TW-1:0] block;
        logic [NW-1:0] neuron;
    } force_req_t;

    typedef enum logic [1:0] {
        IDLE,
        INJECT,
        UPDATE,
        DONE
    } sched_state_t;

    // Out-of-range requests still occupy a queue slot but must not fire.
    function automatic logic req_in_range(input force_req_t r);
        return (int'(r.block) < int'(T)) && (int'(r.neuron) < int'(N));
    endfunction

endpackage

// File: rtl/snn_rr_arbiter.sv
// snn_rr_arbiter: round-robin arbiter with an internal rotating priority pointer.
//   clk, reset : clock, synchronous active-low reset
//   req        : per-requester request lines
//   enable     : when low no grant is issued and the pointer holds
//   grant      : one-hot grant (all zero if nothing granted)
// The pointer moves to winner+1 only when a grant is issued.
module snn_rr_arbiter #(
    parameter int unsigned R = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [R-1:0] req,
    input  logic         enable,
    output logic [R-1:0] grant
);

    localparam int unsigned PW = (R > 1) ? $clog2(R) : 1;

    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        logic [PW-1:0] idx;
        logic          found;
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int unsigned off = 0; off < R; off++) begin
            idx = PW'((32'(ptr_q) + off) % R);
            if (enable && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                ptr_d      = PW'((32'(idx) + 1) % R);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/snn_step_scheduler.sv
// snn_step_scheduler: timestep controller and force-spike arbiter for network_tiny.
//   clk, reset                 : clock, synchronous active-low reset
//   start_step                 : request one timestep (honoured only in IDLE)
//   req_valid/req_block/req_neuron, req_ready : R force-spike requesters, RR arbitrated
//   force_spike_block_select, force_spike_neuron_select, force_spike_en : to network
//   block_update_en            : one-hot block update enable
//   step_busy, step_done       : step in progress / one-cycle completion pulse
//   step_count                 : completed-step counter (wraps)
// All network-facing outputs are registered images of the state of the previous
// cycle, so spike injection and block updates never overlap.
module snn_step_scheduler
    import snn_pkg::*;
#(
    parameter int unsigned R      = 2,
    parameter int unsigned QDEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_step,
    input  logic [R-1:0]          req_valid,
    input  logic [R*TW-1:0]       req_block,
    input  logic [R*NW-1:0]       req_neuron,
    output logic [R-1:0]          req_ready,
    output logic [TW-1:0]         force_spike_block_select,
    output logic [NW-1:0]         force_spike_neuron_select,
    output logic                  force_spike_en,
    output logic [T-1:0]          block_update_en,
    output logic                  step_busy,
    output logic                  step_done,
    output logic [STEP_CNT_W-1:0] step_count
);

    localparam int unsigned AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    // Queue
    force_req_t    mem_q [QDEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [R-1:0]  grant;
    logic          push, pop;
    force_req_t    push_data, head;

    // Sequencer
    sched_state_t          state_q, state_d;
    logic [CW-1:0]         inj_cnt_q, inj_cnt_d;
    logic [TW-1:0]         blk_q, blk_d;
    logic [TW-1:0]         fs_blk_q, fs_blk_d;
    logic [NW-1:0]         fs_nrn_q, fs_nrn_d;
    logic                  fse_q, fse_d;
    logic [T-1:0]          bue_q, bue_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [STEP_CNT_W-1:0] step_count_q, step_count_d;

    // Fullness uses the registered count: a pop in the same cycle does not free a slot.
    snn_rr_arbiter #(.R(R)) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req_valid),
        .enable (reset && (count_q < CW'(QDEPTH))),
        .grant  (grant)
    );

    assign req_ready = grant;
    assign push      = |grant;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        push_data = '0;
        for (int unsigned i = 0; i < R; i++) begin
            if (grant[i]) begin
                push_data.block  = req_block[i*TW +: TW];
                push_data.neuron = req_neuron[i*NW +: NW];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        inj_cnt_d    = inj_cnt_q;
        blk_d        = blk_q;
        pop          = 1'b0;
        fs_blk_d     = fs_blk_q;
        fs_nrn_d     = fs_nrn_q;
        fse_d        = 1'b0;
        bue_d        = '0;
        busy_d       = (state_q != IDLE);
        done_d       = 1'b0;
        step_count_d = step_count_q;
        case (state_q)
            IDLE: begin
                if (start_step) begin
                    // Snapshot of the queue; later arrivals wait for the next step.
                    // An empty snapshot skips INJECT entirely.
                    inj_cnt_d = count_q;
                    state_d   = (count_q == '0) ? UPDATE : INJECT;
                end
            end
            INJECT: begin
                pop       = 1'b1;
                fs_blk_d  = head.block;
                fs_nrn_d  = head.neuron;
                fse_d     = req_in_range(head);
                inj_cnt_d = inj_cnt_q - CW'(1);
                if (inj_cnt_q == CW'(1)) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                bue_d = T'(1) << blk_q;
                if (blk_q == TW'(T - 1)) begin
                    blk_d   = '0;
                    state_d = DONE;
                end else begin
                    blk_d = blk_q + TW'(1);
                end
            end
            DONE: begin
                done_d       = 1'b1;
                step_count_d = step_count_q + STEP_CNT_W'(1);
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= IDLE;
            inj_cnt_q    <= '0;
            blk_q        <= '0;
            fs_blk_q     <= '0;
            fs_nrn_q     <= '0;
            fse_q        <= 1'b0;
            bue_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            step_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_q + AW'(push);
            rd_ptr_q     <= rd_ptr_q + AW'(pop);
            count_q      <= count_q + CW'(push) - CW'(pop);
            state_q      <= state_d;
            inj_cnt_q    <= inj_cnt_d;
            blk_q        <= blk_d;
            fs_blk_q     <= fs_blk_d;
            fs_nrn_q     <= fs_nrn_d;
            fse_q        <= fse_d;
            bue_q        <= bue_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            step_count_q <= step_count_d;
        end
    end

    assign force_spike_block_select  = fs_blk_q;
    assign force_spike_neuron_select = fs_nrn_q;
    assign force_spike_en            = fse_q;
    assign block_update_en           = bue_q;
    assign step_busy                 = busy_q;
    assign step_done                 = done_q;
    assign step_count                = step_count_q;

endmodule

// File: tb/tb_snn_step_scheduler.sv
// tb_snn_step_scheduler: randomized scoreboard bench for snn_step_scheduler.
// The driver keeps a queue-level reference model (FIFO contents, RR pointer,
// step progress) and pushes the expected spike / update / done events; a
// separate monitor pops and compares whenever the DUT presents one.
module tb_snn_step_scheduler;
    import snn_pkg::*;

    localparam int unsigned R  = 2;
    localparam int unsigned QD = 4;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  start_step = 1'b0;
    logic [R-1:0]          req_valid = '0;
    logic [R*TW-1:0]       req_block = '0;
    logic [R*NW-1:0]       req_neuron = '0;
    logic [R-1:0]          req_ready;
    logic [TW-1:0]         fs_block;
    logic [NW-1:0]         fs_neuron;
    logic                  fs_en;
    logic [T-1:0]          bue;
    logic                  step_busy;
    logic                  step_done;
    logic [STEP_CNT_W-1:0] step_count;

    always #5 clk = ~clk;

    snn_step_scheduler #(.R(R), .QDEPTH(QD)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .start_step                (start_step),
        .req_valid                 (req_valid),
        .req_block                 (req_block),
        .req_neuron                (req_neuron),
        .req_ready                 (req_ready),
        .force_spike_block_select  (fs_block),
        .force_spike_neuron_select (fs_neuron),
        .force_spike_en            (fs_en),
        .block_update_en           (bue),
        .step_busy                 (step_busy),
        .step_done                 (step_done),
        .step_count                (step_count)
    );

    int errors = 0;
    int checks = 0;

    typedef enum int {EV_SPIKE, EV_UPD, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        int unsigned a;
        int unsigned b;
    } ev_t;
    typedef struct {
        int unsigned blk;
        int unsigned nrn;
    } ent_t;

    ev_t         exp_q[$];
    int unsigned busy_len_q[$];

    // Reference model state
    ent_t        mq[$];
    int unsigned mptr = 0;
    int unsigned pops_left = 0;
    int unsigned busy_left = 0;
    int unsigned mcnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // One cycle of the reference model, evaluated with this cycle's inputs.
    task automatic model_cycle();
        logic [R-1:0] eg;
        int           w;
        ent_t         e;
        eg = '0;
        w  = -1;
        if (reset && mq.size() < QD) begin
            for (int off = 0; off < int'(R); off++) begin
                int i;
                i = (int'(mptr) + off) % int'(R);
                if (w < 0 && req_valid[i]) w = i;
            end
        end
        if (w >= 0) eg[w] = 1'b1;
        check("grant", 32'(req_ready), 32'(eg));
        if (!reset) begin
            mq.delete();
            exp_q.delete();
            busy_len_q.delete();
            mptr      = 0;
            pops_left = 0;
            busy_left = 0;
            mcnt      = 0;
            return;
        end
        if (pops_left > 0) begin
            void'(mq.pop_front());
            pops_left--;
        end
        if (busy_left > 0) begin
            busy_left--;
        end else if (start_step) begin
            int unsigned k;
            k = mq.size();
            for (int unsigned j = 0; j < k; j++) exp_q.push_back('{EV_SPIKE, mq[j].blk, mq[j].nrn});
            for (int unsigned b = 0; b < T; b++) exp_q.push_back('{EV_UPD, b, 0});
            mcnt = (mcnt + 1) % 65536;
            exp_q.push_back('{EV_DONE, mcnt, 0});
            busy_len_q.push_back(k + T + 1);
            pops_left = k;
            busy_left = k + T + 1;
        end
        if (w >= 0) begin
            e.blk = 32'(req_block[w*TW +: TW]);
            e.nrn = 32'(req_neuron[w*NW +: NW]);
            mq.push_back(e);
            mptr = (w + 1) % R;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        req_block  = (R*TW)'($urandom);
        req_neuron = (R*NW)'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fs_en"}, 32'(fs_en), 0);
        check({tag, "_bue"}, 32'(bue), 0);
        check({tag, "_busy"}, 32'(step_busy), 0);
        check({tag, "_done"}, 32'(step_done), 0);
        check({tag, "_count"}, 32'(step_count), 0);
        check({tag, "_fs_sel"}, 32'({fs_block, fs_neuron}), 0);
    endtask

    // Monitor
    ev_t         mon_e;
    int unsigned run = 0;
    always @(negedge clk) begin
        check("exclusive", 32'(fs_en && (bue != '0)), 0);
        if (fs_en) begin
            if (exp_q.size() == 0) check("spike_unexpected", 1, 0);
            else begin
                mon_e = exp_q.pop_front();
                check("spike_kind", 32'(mon_e.kind), 32'(EV_SPIKE));
                check("spike_block", 32'(fs_block), mon_e.a);
                check("spike_neuron", 32'(fs_neuron), mon_e.b);
            end
        end
        if (bue != '0) begin
            if (exp_q.size() == 0) check("update_unexpected", 1, 0);
            else begin
                mon_e = exp_q.pop_front();
                check("update_kind", 32'(mon_e.kind), 32'(EV_UPD));
                check("update_onehot", 32'(bue), 32'(1) << mon_e.a);
            end
        end
        if (step_done) begin
            if (exp_q.size() == 0) check("done_unexpected", 1, 0);
            else begin
                mon_e = exp_q.pop_front();
                check("done_kind", 32'(mon_e.kind), 32'(EV_DONE));
                check("done_count", 32'(step_count), mon_e.a);
            end
        end
        if (!reset) begin
            run = 0;
        end else if (step_busy) begin
            run++;
        end else if (run > 0) begin
            if (busy_len_q.size() == 0) check("busy_unexpected", 1, 0);
            else check("busy_len", run, busy_len_q.pop_front());
            run = 0;
        end
    end

    initial begin
        int unsigned k;

        // Reset
        reset = 1'b0;
        req_valid = '1;
        repeat (3) tick();
        check_all_zero("reset");
        req_valid = '0;
        reset = 1'b1;

        // Empty-queue step
        start_step = 1'b1; tick(); start_step = 1'b0;
        repeat (8) tick();
        check("t1_count", 32'(step_count), 1);

        // Two pushes from requester 0, then a step
        req_valid = 2'b01;
        req_block = '0;  req_block[TW-1:0] = TW'(2); req_neuron = '0; req_neuron[NW-1:0] = NW'(5);
        tick();
        req_block[TW-1:0] = TW'(1); req_neuron[NW-1:0] = NW'(3);
        tick();
        req_valid = '0;
        start_step = 1'b1; tick(); start_step = 1'b0;
        repeat (10) tick();

        // Both requesters continuously: alternating grants until full
        req_valid = 2'b11;
        repeat (6) begin rand_data(); tick(); end
        // Start with a full queue while pushes continue
        start_step = 1'b1; rand_data(); tick(); start_step = 1'b0;
        repeat (4) begin rand_data(); tick(); end
        req_valid = '0;
        repeat (10) tick();
        // Leftovers from mid-INJECT pushes go first in this step
        start_step = 1'b1; tick(); start_step = 1'b0;
        repeat (12) tick();

        // start_step during UPDATE is ignored
        req_valid = 2'b01;
        repeat (2) begin rand_data(); tick(); end
        req_valid = '0;
        k = mq.size();
        start_step = 1'b1; tick(); start_step = 1'b0;
        repeat (k + 2) tick();
        start_step = 1'b1; tick(); start_step = 1'b0;
        repeat (12) tick();

        // Reset in the middle of INJECT
        req_valid = 2'b10;
        repeat (3) begin rand_data(); tick(); end
        req_valid = '0;
        start_step = 1'b1; tick(); start_step = 1'b0;
        tick();
        reset = 1'b0; tick();
        check_all_zero("midreset");
        reset = 1'b1;
        start_step = 1'b1; tick(); start_step = 1'b0;
        repeat (8) tick();

        // Random traffic
        repeat (400) begin
            req_valid  = R'($urandom);
            rand_data();
            start_step = ($urandom_range(0, 7) == 0);
            tick();
        end
        req_valid = '0;
        start_step = 1'b0;
        repeat (12) tick();

        // Counter wrap
        force dut.step_count_q = 16'hFFFF;
        mcnt = 65535;
        @(negedge clk);
        release dut.step_count_q;
        #1;
        model_cycle();
        @(posedge clk);
        #1;
        start_step = 1'b1; tick(); start_step = 1'b0;
        for (int i = 0; i < 40 && busy_left > 0; i++) tick();
        repeat (3) tick();
        check("wrap_count", 32'(step_count), 0);
        check("events_drained", 32'(exp_q.size()), 0);
        check("busy_drained", 32'(busy_len_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
